// File: rtl/geriyaz_hakem_pkg.sv
// rtl/geriyaz_hakem_pkg.sv - shared widths, requester indices and helpers for the writeback arbiter
package geriyaz_hakem_pkg;

    localparam int VERI_BIT               = 32;
    localparam int YAZMAC_BIT             = 5;
    localparam int UOP_TAG_BIT            = 6;
    localparam int GERIYAZ_ISTEKCI_SAYISI = 4;

    localparam int ISTEKCI_ALU     = 0;
    localparam int ISTEKCI_BELLEK  = 1;
    localparam int ISTEKCI_CARPBOL = 2;
    localparam int ISTEKCI_CSR     = 3;

    // Wait counters are 8 bits wide so any threshold up to 255 fits.
    localparam int SAYAC_BIT = 8;

    function automatic int ptr_genisligi(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/geriyaz_hakem_rr_secici.sv
// rtl/geriyaz_hakem_rr_secici.sv - round-robin first-one finder: request mask and start pointer to one-hot
module geriyaz_hakem_rr_secici #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     istek,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     secim
);

    int   idx;
    logic bulundu;

    // Scan ptr, ptr+1, ... wrapping at N; the first set bit wins.
    always_comb begin
        secim   = '0;
        bulundu = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!bulundu && istek[idx]) begin
                secim[idx] = 1'b1;
                bulundu    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/geriyaz_hakem.sv
// rtl/geriyaz_hakem.sv - register-file writeback port arbiter with round-robin, priority and starvation override
module geriyaz_hakem
    import geriyaz_hakem_pkg::*;
#(
    parameter int ISTEKCI_SAYISI    = GERIYAZ_ISTEKCI_SAYISI,
    parameter int VERI_BIT          = geriyaz_hakem_pkg::VERI_BIT,
    parameter int YAZMAC_BIT        = geriyaz_hakem_pkg::YAZMAC_BIT,
    parameter int ETIKET_BIT        = UOP_TAG_BIT,
    parameter bit ONCELIK_EN        = 1'b1,
    parameter int ONCELIKLI_ISTEKCI = ISTEKCI_BELLEK,
    parameter int ACLIK_SINIRI      = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [ISTEKCI_SAYISI-1:0]            istek_gecerli_i,
    output logic [ISTEKCI_SAYISI-1:0]            istek_hazir_o,
    input  logic [ISTEKCI_SAYISI*VERI_BIT-1:0]   istek_veri_i,
    input  logic [ISTEKCI_SAYISI*YAZMAC_BIT-1:0] istek_adres_i,
    input  logic [ISTEKCI_SAYISI*ETIKET_BIT-1:0] istek_etiket_i,
    output logic [VERI_BIT-1:0]                  geriyaz_veri_o,
    output logic [YAZMAC_BIT-1:0]                geriyaz_adres_o,
    output logic [ETIKET_BIT-1:0]                geriyaz_etiket_o,
    output logic                                 geriyaz_gecerli_o,
    output logic [ISTEKCI_SAYISI-1:0]            aclik_o
);

    localparam int N     = ISTEKCI_SAYISI;
    localparam int PTR_W = ptr_genisligi(N);
    localparam logic [SAYAC_BIT-1:0] SINIR = SAYAC_BIT'(ACLIK_SINIRI);

    logic [PTR_W-1:0]     ptr_q;
    logic [SAYAC_BIT-1:0] sayac_q [N];

    logic [N-1:0]          aclik_vec;
    logic [N-1:0]          aclik_aday;
    logic [N-1:0]          rr_secim;
    logic [N-1:0]          aclik_secim;
    logic [N-1:0]          hazir;
    logic                  transfer;
    logic [PTR_W-1:0]      secilen_idx;
    logic [PTR_W-1:0]      ptr_sonraki;
    logic [VERI_BIT-1:0]   secilen_veri;
    logic [YAZMAC_BIT-1:0] secilen_adres;
    logic [ETIKET_BIT-1:0] secilen_etiket;

    always_comb begin
        aclik_vec = '0;
        for (int i = 0; i < N; i++) begin
            aclik_vec[i] = (sayac_q[i] >= SINIR);
        end
    end

    assign aclik_o    = aclik_vec;
    assign aclik_aday = istek_gecerli_i & aclik_vec;

    geriyaz_hakem_rr_secici #(.N(N), .PTR_W(PTR_W)) u_rr_secici (
        .istek (istek_gecerli_i),
        .ptr   (ptr_q),
        .secim (rr_secim)
    );

    // Starved requesters are served lowest index first, so scan from 0.
    geriyaz_hakem_rr_secici #(.N(N), .PTR_W(PTR_W)) u_aclik_secici (
        .istek (aclik_aday),
        .ptr   ('0),
        .secim (aclik_secim)
    );

    always_comb begin
        hazir = '0;
        if (rst_i) begin
            hazir = '0;
        end else if (N == 1) begin
            hazir = istek_gecerli_i;
        end else if (|aclik_aday) begin
            hazir = aclik_secim;
        end else if (ONCELIK_EN && istek_gecerli_i[ONCELIKLI_ISTEKCI]) begin
            hazir[ONCELIKLI_ISTEKCI] = 1'b1;
        end else begin
            hazir = rr_secim;
        end
    end

    assign istek_hazir_o = hazir;
    assign transfer      = |hazir;

    // Grant is one-hot, so a plain priority walk selects the payload.
    always_comb begin
        secilen_idx    = '0;
        secilen_veri   = '0;
        secilen_adres  = '0;
        secilen_etiket = '0;
        for (int i = 0; i < N; i++) begin
            if (hazir[i]) begin
                secilen_idx    = PTR_W'(i);
                secilen_veri   = istek_veri_i[i*VERI_BIT +: VERI_BIT];
                secilen_adres  = istek_adres_i[i*YAZMAC_BIT +: YAZMAC_BIT];
                secilen_etiket = istek_etiket_i[i*ETIKET_BIT +: ETIKET_BIT];
            end
        end
    end

    assign ptr_sonraki = (secilen_idx == PTR_W'(N - 1)) ? '0 : secilen_idx + 1'b1;

    // Writes to x0 still complete the handshake but never reach the register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            geriyaz_veri_o    <= '0;
            geriyaz_adres_o   <= '0;
            geriyaz_etiket_o  <= '0;
            geriyaz_gecerli_o <= 1'b0;
            ptr_q             <= '0;
        end else begin
            geriyaz_gecerli_o <= transfer && (secilen_adres != '0);
            if (transfer) begin
                geriyaz_veri_o   <= secilen_veri;
                geriyaz_adres_o  <= secilen_adres;
                geriyaz_etiket_o <= secilen_etiket;
                ptr_q            <= ptr_sonraki;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (rst_i || !(istek_gecerli_i[i] && !hazir[i])) begin
                sayac_q[i] <= '0;
            end else if (sayac_q[i] < SINIR) begin
                sayac_q[i] <= sayac_q[i] + 1'b1;
            end
        end
    end

endmodule
